// File: rtl/sequence_generator_if.sv
`default_nettype none
// ============================================================================
//  Module      : sequence_generator_if
//  Description : Control/serial-stream bundle for the sequence generator.
//  Revision    : 1.0 - initial release
// ============================================================================
interface sequence_generator_if #(
    parameter int WIDTH = 5,
    parameter int CNT_W = 8,
    parameter int GAP_W = 4
);
    localparam int LEN_W = $clog2(WIDTH + 1);

    logic             start;
    logic [WIDTH-1:0] pattern;
    logic [LEN_W-1:0] len;
    logic [CNT_W-1:0] repeat_n;
    logic [GAP_W-1:0] gap;
    logic             abort;
    logic             x_out;
    logic             x_valid;
    logic             busy;
    logic             done;

    modport master (
        output start, pattern, len, repeat_n, gap, abort,
        input  x_out, x_valid, busy, done
    );

    modport slave (
        input  start, pattern, len, repeat_n, gap, abort,
        output x_out, x_valid, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/sequence_generator.sv
`default_nettype none
// ============================================================================
//  Module      : sequence_generator
//  Description : Captures a pattern on start and shifts it out MSB-first,
//                optionally repeating it with programmable idle gaps.
//  Revision    : 1.0 - initial release
// ============================================================================
module sequence_generator #(
    parameter int WIDTH = 5,
    parameter int CNT_W = 8,
    parameter int GAP_W = 4
) (
    input  wire                  clk,
    input  wire                  reset,
    sequence_generator_if.slave  bus
);
    localparam int              LW        = $clog2(WIDTH + 1);
    localparam logic [LW-1:0]   c_WIDTH_L = LW'(WIDTH);
    localparam logic [LW-1:0]   c_ONE_L   = LW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pat_q, pat_d;
    logic [LW-1:0]    len_q, len_d;
    logic [LW-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0] rep_q, rep_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [GAP_W-1:0] gcnt_q, gcnt_d;
    logic             x_out_q, x_out_d;
    logic             x_valid_q, x_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [LW-1:0]    w_len_eff;

    // Zero or out-of-range lengths fall back to the full pattern width.
    assign w_len_eff = ((bus.len == '0) || (bus.len > c_WIDTH_L)) ? c_WIDTH_L : bus.len;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            pat_q     <= '0;
            len_q     <= '0;
            idx_q     <= '0;
            rep_q     <= '0;
            gap_q     <= '0;
            gcnt_q    <= '0;
            x_out_q   <= 1'b0;
            x_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pat_q     <= pat_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            rep_q     <= rep_d;
            gap_q     <= gap_d;
            gcnt_q    <= gcnt_d;
            x_out_q   <= x_out_d;
            x_valid_q <= x_valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        len_d   = len_q;
        idx_d   = idx_q;
        rep_d   = rep_q;
        gap_d   = gap_q;
        gcnt_d  = gcnt_q;
        done_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start && !bus.abort) begin
                    pat_d   = bus.pattern;
                    len_d   = w_len_eff;
                    rep_d   = bus.repeat_n;
                    gap_d   = bus.gap;
                    idx_d   = w_len_eff - c_ONE_L;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                end else if (idx_q == '0) begin
                    if (rep_q == '0) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        rep_d = rep_q - 1'b1;
                        if (gap_q == '0) begin
                            idx_d = len_q - c_ONE_L;
                        end else begin
                            gcnt_d  = gap_q;
                            state_d = ST_GAP;
                        end
                    end
                end else begin
                    idx_d = idx_q - c_ONE_L;
                end
            end
            ST_GAP: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                end else if (gcnt_q <= GAP_W'(1)) begin
                    gcnt_d  = '0;
                    idx_d   = len_q - c_ONE_L;
                    state_d = ST_SEND;
                end else begin
                    gcnt_d = gcnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are a registered image of the next state.
        x_valid_d = (state_d == ST_SEND);
        busy_d    = (state_d != ST_IDLE);
        x_out_d   = x_valid_d & pat_d[idx_d];
    end

    assign bus.x_out   = x_out_q;
    assign bus.x_valid = x_valid_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
endmodule
`default_nettype wire

// File: tb/tb_sequence_generator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sequence_generator
//  Description : Directed and random stimulus against a per-cycle expected
//                output stream built from the pattern/repeat/gap rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sequence_generator;
    localparam int WIDTH = 5;
    localparam int CNT_W = 8;
    localparam int GAP_W = 4;
    localparam int LW    = $clog2(WIDTH + 1);

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sequence_generator_if #(.WIDTH(WIDTH), .CNT_W(CNT_W), .GAP_W(GAP_W)) bus ();

    sequence_generator #(.WIDTH(WIDTH), .CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Expected output word per cycle: {x_valid, x_out, busy, done}
    logic [3:0] exp_q[$];
    logic [3:0] cur;
    int vectors;
    int miscompares;

    task automatic load_stream();
        int L;
        L = (bus.len == 0 || int'(bus.len) > WIDTH) ? WIDTH : int'(bus.len);
        exp_q.delete();
        for (int r = 0; r <= int'(bus.repeat_n); r++) begin
            for (int b = L - 1; b >= 0; b--)
                exp_q.push_back({1'b1, bus.pattern[b], 1'b1, 1'b0});
            if (r < int'(bus.repeat_n))
                for (int g = 0; g < int'(bus.gap); g++)
                    exp_q.push_back(4'b0010);
        end
        exp_q.push_back(4'b0001);
    endtask

    task automatic cyc(input logic s, input logic a, input logic r, input string tag);
        logic [3:0] obs;
        logic       was_busy;
        was_busy  = cur[1];
        bus.start = s;
        bus.abort = a;
        reset     = r;
        if (r)                       exp_q.delete();
        else if (was_busy && a)      exp_q.delete();
        else if (!was_busy && s && !a) load_stream();
        cur = (exp_q.size() > 0) ? exp_q.pop_front() : 4'b0000;
        @(posedge clk);
        #1;
        obs = {bus.x_valid, bus.x_out, bus.busy, bus.done};
        vectors++;
        assert (obs === cur) else begin
            miscompares++;
            $error("FAIL %s: {valid,x,busy,done} observed=%b expected=%b", tag, obs, cur);
        end
    endtask

    task automatic setup(input logic [WIDTH-1:0] p, input int l, input int rn, input int g);
        bus.pattern  = p;
        bus.len      = LW'(l);
        bus.repeat_n = CNT_W'(rn);
        bus.gap      = GAP_W'(g);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, tag);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        cur = 4'b0000;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        setup(5'b10101, 5, 0, 0);
        cyc(1'b0, 1'b0, 1'b1, "reset");
        cyc(1'b0, 1'b0, 1'b1, "reset");
        idle(2, "post_reset");

        setup(5'b10101, 5, 0, 0);
        cyc(1'b1, 1'b0, 1'b0, "single");
        idle(8, "single");

        setup(5'b10101, 5, 2, 0);
        cyc(1'b1, 1'b0, 1'b0, "b2b");
        idle(18, "b2b");

        setup(5'b10101, 5, 1, 3);
        cyc(1'b1, 1'b0, 1'b0, "gap3");
        idle(16, "gap3");

        setup(5'b00110, 3, 0, 0);
        cyc(1'b1, 1'b0, 1'b0, "len3");
        idle(5, "len3");

        setup(5'b11001, 0, 0, 0);
        cyc(1'b1, 1'b0, 1'b0, "len0");
        idle(7, "len0");

        setup(5'b10110, 7, 0, 1);
        cyc(1'b1, 1'b0, 1'b0, "len_big");
        idle(7, "len_big");

        // Inputs changed and start re-pulsed mid-stream, then aborted.
        setup(5'b10101, 5, 0, 0);
        cyc(1'b1, 1'b0, 1'b0, "ignore_start");
        setup(5'b01010, 2, 4, 2);
        cyc(1'b1, 1'b0, 1'b0, "ignore_start");
        cyc(1'b0, 1'b1, 1'b0, "abort");
        idle(3, "abort");
        cyc(1'b1, 1'b1, 1'b0, "abort_start_idle");
        idle(2, "abort_start_idle");

        // Start accepted on the done cycle.
        setup(5'b10101, 5, 0, 0);
        cyc(1'b1, 1'b0, 1'b0, "start_on_done");
        idle(5, "start_on_done");
        setup(5'b11100, 5, 0, 0);
        cyc(1'b1, 1'b0, 1'b0, "start_on_done");
        idle(7, "start_on_done");

        // Reset during a gap, then a fresh transmission.
        setup(5'b10101, 5, 3, 5);
        cyc(1'b1, 1'b0, 1'b0, "reset_gap");
        idle(7, "reset_gap");
        cyc(1'b0, 1'b0, 1'b1, "reset_gap");
        setup(5'b10011, 5, 0, 0);
        cyc(1'b1, 1'b0, 1'b0, "after_reset");
        idle(7, "after_reset");

        // Maximum repeat count: 256 one-bit sends.
        setup(5'b00001, 1, 255, 0);
        cyc(1'b1, 1'b0, 1'b0, "repeat_max");
        idle(260, "repeat_max");

        // Abort during a gap.
        setup(5'b11011, 4, 2, 4);
        cyc(1'b1, 1'b0, 1'b0, "abort_gap");
        idle(5, "abort_gap");
        cyc(1'b0, 1'b1, 1'b0, "abort_gap");
        idle(3, "abort_gap");

        for (int i = 0; i < 1500; i++) begin
            setup(WIDTH'($urandom), int'($urandom_range(0, 7)),
                  ($urandom_range(0, 9) == 0) ? int'($urandom_range(4, 20)) : int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)));
            cyc($urandom_range(0, 99) < 20, $urandom_range(0, 99) < 3,
                $urandom_range(0, 199) == 0, "random");
        end
        idle(10, "drain");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
